param_regfile_ce: RTL and testbench
===================================

Name: param_regfile_ce

Overview:
Parametrised multi-entry register file; generalises the single CE/reset-valued register into an array.
- DEPTH entries, each with its own reset value.
- One masked write port and two combinational read ports.
- Optional write-to-read bypass and per-entry read-only protection.
- Registered write-error reporting with a saturating error counter.
- Sits beside the datapath as the architectural register bank.

Parameters:
WIDTH, 32, bits per entry; must be a multiple of 8 and ≥ 8.
DEPTH, 4, number of entries; 2..64, need not be a power of 2.
AW, max(1,clog2(DEPTH)), address width; derived, not overridable.
INIT_VALUES, {entry1='h00000018, all others 0}, flat DEPTH*WIDTH vector; entry i occupies bits [i*WIDTH +: WIDTH].
RO_MASK, 0, DEPTH bits; bit i=1 makes entry i read-only (holds its INIT value permanently).
BYPASS, 0, 1 = a read of the address being written returns the post-write value in the same cycle.
ERR_W, 8, width of the error counter.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
ASYNCRESET  input  1  asynchronous, active-high reset; forces every entry to its INIT value and clears all error state.
CLR  input  1  synchronous soft clear; same effect as ASYNCRESET, taken at the clock edge.
WE  input  1  write enable (clock enable of the addressed entry).
WADDR  input  AW  write address.
WDATA  input  WIDTH  write data.
WMASK  input  WIDTH/8  byte enables; bit b covers WDATA[8b+7:8b].
RADDR0  input  AW  read address, port 0.
RDATA0  output  WIDTH  read data, port 0.
RADDR1  input  AW  read address, port 1.
RDATA1  output  WIDTH  read data, port 1.
WERR  output  1  registered one-cycle pulse flagging an illegal write.
ERR_CNT  output  ERR_W  saturating count of illegal writes.

Behaviour:
- Reset (ASYNCRESET=1, asynchronous assertion):
  - entry[i] = INIT_VALUES[i]; WERR = 0; ERR_CNT = 0.
  - All inputs are ignored while reset is held.
  - The first write is accepted on the first rising CLK edge after deassertion.
- Legal write: WE=1, WADDR<DEPTH, RO_MASK[WADDR]=0.
  - At the edge, each byte b with WMASK[b]=1 takes the WDATA byte; bytes with WMASK[b]=0 hold.
  - WMASK=0 is legal: nothing changes and no error is raised.
- Illegal write: WE=1 and (WADDR≥DEPTH or RO_MASK[WADDR]=1).
  - No entry changes.
  - WERR=1 in the following cycle.
  - ERR_CNT increments by 1, saturating at 2^ERR_W−1.
- WE=0: every entry holds its value; WERR=0 next cycle.
- CLR=1 at an edge: all entries reload their INIT values; WERR=0; ERR_CNT=0.
  - CLR overrides a simultaneous WE, including an illegal one: no error is counted.
- Reads are combinational, with zero cycles of latency.
  - RDATAn = entry[RADDRn] when RADDRn<DEPTH, else 0.
  - Both ports may address the same entry.
- Read of the address being written:
  - BYPASS=0: returns the pre-write value; the new value is visible from the cycle after the edge.
  - BYPASS=1, and the write is legal with CLR=0: returns the byte-merged post-write value in the same cycle.
  - BYPASS=1, but the write is illegal or CLR=1: no bypass; the stored value is returned.
- Read-only entries always read their INIT value.
- Reset asserted mid-operation overrides everything immediately: any in-flight write is lost and ERR_CNT clears.
- No X may propagate to RDATA from an out-of-range address.

Test Plan:
- Reset value check. Stimulus: defaults; assert ASYNCRESET between clock edges; read RADDR0=0 and RADDR1=1. Required: RDATA0=0 and RDATA1='h18 immediately, before any CLK edge.
- Masked write. Stimulus: write WADDR=2, WDATA='hAABBCCDD, WMASK='b0101; next cycle read addr 2. Required: RDATA='h00BB00DD.
- Bypass, both settings. Stimulus: same-cycle write and read of entry 3, WDATA='h12345678, WMASK='hF. Required: BYPASS=0 gives RDATA0=0 that cycle and 'h12345678 the next; BYPASS=1 gives 'h12345678 in the same cycle.
- Read-only entry. Stimulus: RO_MASK='b0010; write 'hFFFFFFFF to entry 1. Required: entry 1 stays 'h18; WERR=1 for exactly one cycle; ERR_CNT=1.
- Out-of-range and saturation. Stimulus: DEPTH=3; write to WADDR=3 for 300 consecutive cycles; then read RADDR0=3. Required: entries unchanged; ERR_CNT saturates at 255; RDATA0=0.
- Clear versus write. Stimulus: entry 2 = 'h55; one cycle with CLR=1 and a write of 'h77 to entry 2. Required: entry 2 reads 0 next cycle; ERR_CNT=0; WERR=0.

Source files
------------

// File: rtl/param_regfile_ce.sv
// rtl/param_regfile_ce.sv - parametrised register file with masked write, two read ports,
// optional bypass, read-only entries and saturating write-error counter.
module param_regfile_ce #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DEPTH*WIDTH-1:0] INIT_VALUES = (DEPTH*WIDTH)'(24) << WIDTH,
  parameter logic [DEPTH-1:0] RO_MASK = '0,
  parameter bit BYPASS = 1'b0,
  parameter int ERR_W = 8
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic               CLR,
  input  logic               WE,
  input  logic [AW-1:0]      WADDR,
  input  logic [WIDTH-1:0]   WDATA,
  input  logic [WIDTH/8-1:0] WMASK,
  input  logic [AW-1:0]      RADDR0,
  output logic [WIDTH-1:0]   RDATA0,
  input  logic [AW-1:0]      RADDR1,
  output logic [WIDTH-1:0]   RDATA1,
  output logic               WERR,
  output logic [ERR_W-1:0]   ERR_CNT
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] wr_hit;
  logic             hit_any;
  logic             hit_ro;
  logic             wr_legal;
  logic             wr_err;
  logic [WIDTH-1:0] cur_w;
  logic [WIDTH-1:0] merged;

  // One-hot decode keeps out-of-range addresses from indexing past the array.
  always_comb begin
    wr_hit = '0;
    cur_w  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i] = (WADDR == AW'(i));
      if (wr_hit[i]) cur_w = mem[i];
    end
    hit_any  = |wr_hit;
    hit_ro   = |(wr_hit & RO_MASK);
    wr_legal = WE & ~CLR & ~ASYNCRESET & hit_any & ~hit_ro;
    wr_err   = WE & ~CLR & (~hit_any | hit_ro);
    merged   = cur_w;
    for (int b = 0; b < WIDTH/8; b++) begin
      if (WMASK[b]) merged[b*8 +: 8] = WDATA[b*8 +: 8];
    end
  end

  always_comb begin
    RDATA0 = '0;
    RDATA1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RADDR0 == AW'(i)) RDATA0 = (BYPASS && wr_legal && wr_hit[i]) ? merged : mem[i];
      if (RADDR1 == AW'(i)) RDATA1 = (BYPASS && wr_legal && wr_hit[i]) ? merged : mem[i];
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VALUES[i*WIDTH +: WIDTH];
      WERR    <= 1'b0;
      ERR_CNT <= '0;
    end else if (CLR) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VALUES[i*WIDTH +: WIDTH];
      WERR    <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_legal && wr_hit[i]) mem[i] <= merged;
      end
      WERR <= wr_err;
      if (wr_err && (ERR_CNT != {ERR_W{1'b1}})) ERR_CNT <= ERR_CNT + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_param_regfile_ce.sv
// tb/tb_param_regfile_ce.sv - three configurations of param_regfile_ce checked against
// an array-based reference model with directed and randomized steps.
module tb_param_regfile_ce;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic [1:0]  raddr0 = '0;
  logic [1:0]  raddr1 = '0;

  logic [2:0][31:0] rd0;
  logic [2:0][31:0] rd1;
  logic [2:0]       werr;
  logic [2:0][7:0]  cnt;

  int tests = 0;
  int fails = 0;

  // Configurations: a = defaults, b = bypass + entry 1 read-only, c = depth 3.
  int          cfg_depth [3] = '{4, 4, 3};
  logic [3:0]  cfg_ro    [3] = '{4'b0000, 4'b0010, 4'b0000};
  bit          cfg_byp   [3] = '{1'b0, 1'b1, 1'b0};

  logic [31:0] m_mem  [3][4];
  int          m_cnt  [3];
  logic        m_werr [3];

  always #5 clk = ~clk;

  param_regfile_ce #(.DEPTH(4)) dut_a (
    .CLK(clk), .ASYNCRESET(rst), .CLR(clr), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .WMASK(wmask), .RADDR0(raddr0), .RDATA0(rd0[0]), .RADDR1(raddr1), .RDATA1(rd1[0]),
    .WERR(werr[0]), .ERR_CNT(cnt[0]));

  param_regfile_ce #(.DEPTH(4), .RO_MASK(4'b0010), .BYPASS(1'b1)) dut_b (
    .CLK(clk), .ASYNCRESET(rst), .CLR(clr), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .WMASK(wmask), .RADDR0(raddr0), .RDATA0(rd0[1]), .RADDR1(raddr1), .RDATA1(rd1[1]),
    .WERR(werr[1]), .ERR_CNT(cnt[1]));

  param_regfile_ce #(.DEPTH(3)) dut_c (
    .CLK(clk), .ASYNCRESET(rst), .CLR(clr), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .WMASK(wmask), .RADDR0(raddr0), .RDATA0(rd0[2]), .RADDR1(raddr1), .RDATA1(rd1[2]),
    .WERR(werr[2]), .ERR_CNT(cnt[2]));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic bit legal(input int k);
    return we && !clr && (int'(waddr) < cfg_depth[k]) && !cfg_ro[k][waddr];
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [1:0] a);
    if (int'(a) >= cfg_depth[k]) return 32'h0;
    if (cfg_byp[k] && !rst && legal(k) && a == waddr) return merge(m_mem[k][a], wdata, wmask);
    return m_mem[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) m_mem[k][i] = (i == 1) ? 32'h18 : 32'h0;
      m_cnt[k]  = 0;
      m_werr[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst || clr) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (legal(k)) m_mem[k][waddr] = merge(m_mem[k][waddr], wdata, wmask);
      m_werr[k] = we && !legal(k);
      if (m_werr[k] && m_cnt[k] < 255) m_cnt[k]++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rdata0[%0d]@%0d", k, raddr0), rd0[k], model_read(k, raddr0));
      chk($sformatf("rdata1[%0d]@%0d", k, raddr1), rd1[k], model_read(k, raddr1));
      chk($sformatf("werr[%0d]", k), {31'b0, werr[k]}, {31'b0, m_werr[k]});
      chk($sformatf("err_cnt[%0d]", k), {24'b0, cnt[k]}, 32'(m_cnt[k]));
    end
  endtask

  task automatic step();
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; clr = 1'b0; wmask = 4'h0;
  endtask

  initial begin
    // Reset asserted between edges must show INIT values before any clock edge.
    raddr0 = 2'd0; raddr1 = 2'd1;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("reset_rd0_a", rd0[0], 32'h0);
    chk("reset_rd1_a", rd1[0], 32'h18);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Masked write, visible next cycle.
    we = 1'b1; waddr = 2'd2; wdata = 32'hAABBCCDD; wmask = 4'b0101; raddr0 = 2'd2;
    step();
    idle();
    #1 chk("masked_a", rd0[0], 32'h00BB00DD);
    step();

    // Same-cycle write/read of entry 3: only the bypass configuration sees new data.
    we = 1'b1; waddr = 2'd3; wdata = 32'h12345678; wmask = 4'hF; raddr0 = 2'd3;
    #1;
    chk("nobyp_same_a", rd0[0], 32'h0);
    chk("byp_same_b", rd0[1], 32'h12345678);
    step();
    idle();
    #1 chk("nobyp_next_a", rd0[0], 32'h12345678);
    step();

    // Write to read-only entry 1 of dut_b.
    we = 1'b1; waddr = 2'd1; wdata = 32'hFFFFFFFF; wmask = 4'hF; raddr1 = 2'd1;
    step();
    idle();
    #1;
    chk("ro_hold_b", rd1[1], 32'h18);
    chk("ro_werr_b", {31'b0, werr[1]}, 32'h1);
    chk("ro_cnt_b", {24'b0, cnt[1]}, 32'h1);
    step();
    chk("ro_werr_drop_b", {31'b0, werr[1]}, 32'h0);

    // Out-of-range writes to dut_c until the counter saturates.
    for (int n = 0; n < 300; n++) begin
      we = 1'b1; waddr = 2'd3; wdata = $urandom; wmask = 4'($urandom);
      raddr0 = 2'd3; raddr1 = 2'($urandom_range(0, 2));
      step();
    end
    idle();
    #1;
    chk("sat_cnt_c", {24'b0, cnt[2]}, 32'd255);
    chk("oor_read_c", rd0[2], 32'h0);
    step();

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom); waddr = 2'($urandom); wdata = $urandom; wmask = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      raddr0 = 2'($urandom); raddr1 = 2'($urandom);
      step();
    end
    idle();

    // Reset mid-operation: in-flight write lost, state back to INIT at once.
    we = 1'b1; waddr = 2'd0; wdata = 32'hDEADBEEF; wmask = 4'hF; raddr0 = 2'd0; raddr1 = 2'd1;
    step();
    we = 1'b1; waddr = 2'd3; wdata = 32'hCAFEF00D;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_rd0_a", rd0[0], 32'h0);
    chk("midrst_rd1_b", rd1[1], 32'h18);
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b0;
    idle();
    step();

    // Clear beats a simultaneous write.
    we = 1'b1; waddr = 2'd2; wdata = 32'h55; wmask = 4'hF; raddr0 = 2'd2;
    step();
    clr = 1'b1; wdata = 32'h77;
    step();
    idle();
    #1;
    chk("clr_rd_a", rd0[0], 32'h0);
    chk("clr_cnt_a", {24'b0, cnt[0]}, 32'h0);
    chk("clr_werr_a", {31'b0, werr[0]}, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
